dice_roll_scheduler: RTL and testbench

Shares the single free-running dice random source (3-bit value 0–5 per clock) among N player roll requests. Grants one player at a time with round-robin fairness and runs a fixed-length roll animation. At the end of the roll it captures the final face (1–6), then holds the result until the consumer acknowledges it. Sits between the player input debouncers and the display/score logic; the random source runs unmodified.

---
 rtl/dice_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/dice_roll_scheduler.sv | 154 +++++++++++++++
 tb/tb_dice_roll_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and the random-value-to-face mapping for the dice roll scheduler.
package dice_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRoll,
        StDone
    } state_t;

    typedef logic [2:0] face_t;

    localparam face_t FACE_MIN = 3'd1;
    localparam face_t FACE_MAX = 3'd6;

    // Out-of-range generator values (6, 7) fold onto the lowest face.
    function automatic face_t to_face(input logic [2:0] rnd);
        if (rnd >= FACE_MAX) begin
            return FACE_MIN;
        end
        return rnd + FACE_MIN;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned N_PLAYERS = 2,
    localparam int unsigned PW = $clog2(N_PLAYERS)
) (
    input  logic                 en,
    input  logic [N_PLAYERS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [N_PLAYERS-1:0] gnt,
    output logic [PW-1:0]        idx,
    output logic                 valid
);

    always_comb begin
        int unsigned j;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            j = (32'(ptr) + i) % N_PLAYERS;
            if (en && !valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/dice_roll_scheduler.sv
// Round-robin dice roll scheduler: grants one player, animates, captures and holds a face.
// Define DICE_ANIM_EN for the multi-cycle animated roll; otherwise the roll lasts one cycle.
module dice_roll_scheduler #(
    parameter int unsigned N_PLAYERS   = 2,
    parameter int unsigned ROLL_CYCLES = 16,
    localparam int unsigned PW = $clog2(N_PLAYERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PLAYERS-1:0] req,
    input  logic [2:0]           rnd_in,
    input  logic                 res_ack,
    output logic [N_PLAYERS-1:0] gnt,
    output logic                 busy,
    output logic [2:0]           anim_face,
    output logic                 res_valid,
    output logic [2:0]           res_face,
    output logic [PW-1:0]        res_player
);

    import dice_pkg::*;

    if (N_PLAYERS < 2 || N_PLAYERS > 8 || ROLL_CYCLES == 0) begin : g_bad_params
        $error("dice_roll_scheduler: illegal N_PLAYERS or ROLL_CYCLES");
    end

    state_t                 state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [N_PLAYERS-1:0]   gnt_q, gnt_d;
    logic                   busy_q, busy_d;
    logic                   res_valid_q, res_valid_d;
    face_t                  res_face_q, res_face_d;
    logic [PW-1:0]          res_player_q, res_player_d;

    logic [N_PLAYERS-1:0]   arb_gnt;
    logic [PW-1:0]          arb_idx;
    logic                   arb_valid;

`ifdef DICE_ANIM_EN
    localparam int unsigned CntW = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;

    logic [CntW-1:0]        cnt_q, cnt_d;
    face_t                  anim_q, anim_d;
`endif

    rr_arbiter #(
        .N_PLAYERS (N_PLAYERS)
    ) u_arb (
        .en    (state_q == StIdle),
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        busy_d       = busy_q;
        res_valid_d  = res_valid_q;
        res_face_d   = res_face_q;
        res_player_d = res_player_q;
`ifdef DICE_ANIM_EN
        cnt_d        = cnt_q;
        anim_d       = anim_q;
`endif
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gnt_d        = arb_gnt;
                    res_player_d = arb_idx;
                    busy_d       = 1'b1;
`ifdef DICE_ANIM_EN
                    cnt_d        = CntW'(ROLL_CYCLES - 1);
`endif
                    state_d      = StRoll;
                end
            end
            StRoll: begin
`ifdef DICE_ANIM_EN
                anim_d = to_face(rnd_in);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    res_face_d  = to_face(rnd_in);
                    res_valid_d = 1'b1;
                    anim_d      = '0;
                    state_d     = StDone;
                end
`else
                res_face_d  = to_face(rnd_in);
                res_valid_d = 1'b1;
                state_d     = StDone;
`endif
            end
            StDone: begin
                if (res_ack) begin
                    res_valid_d = 1'b0;
                    gnt_d       = '0;
                    busy_d      = 1'b0;
                    ptr_d       = (res_player_q == PW'(N_PLAYERS - 1)) ? '0
                                                                      : res_player_q + PW'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_face_q   <= '0;
            res_player_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
            res_face_q   <= res_face_d;
            res_player_q <= res_player_d;
        end
    end

`ifdef DICE_ANIM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            anim_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            anim_q <= anim_d;
        end
    end

    assign anim_face = anim_q;
`else
    assign anim_face = '0;
`endif

    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign res_face   = res_face_q;
    assign res_player = res_player_q;

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Scoreboard bench for dice_roll_scheduler with N_PLAYERS = 2, ROLL_CYCLES = 4.
module tb_dice_roll_scheduler;

    localparam int unsigned NP = 2;
    localparam int unsigned RC = 4;
`ifdef DICE_ANIM_EN
    localparam int LAT  = RC;
    localparam bit ANIM = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit ANIM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] req = '0;
    logic [2:0]    rnd_in = '0;
    logic          res_ack = 1'b0;
    logic [NP-1:0] gnt;
    logic          busy;
    logic [2:0]    anim_face;
    logic          res_valid;
    logic [2:0]    res_face;
    logic [0:0]    res_player;

    typedef struct {
        logic [2:0] face;
        int         player;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   grant_cyc = 0;

    dice_roll_scheduler #(
        .N_PLAYERS   (NP),
        .ROLL_CYCLES (RC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .rnd_in     (rnd_in),
        .res_ack    (res_ack),
        .gnt        (gnt),
        .busy       (busy),
        .anim_face  (anim_face),
        .res_valid  (res_valid),
        .res_face   (res_face),
        .res_player (res_player)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected result when res_valid rises; tracks animation while busy.
    initial begin
        logic [1:0] gnt_prev;
        logic       rv_prev;
        logic [2:0] exp_anim;
        exp_t       e;
        gnt_prev = '0;
        rv_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gnt_prev = '0;
                rv_prev  = 1'b0;
            end else begin
                if (gnt != '0 && gnt_prev == '0) grant_cyc = cyc;
                if (busy) begin
                    exp_anim = 3'd0;
                    if (ANIM && !res_valid && cyc > grant_cyc && sb.size() > 0)
                        exp_anim = sb[0].face;
                    chk("anim_face", int'(anim_face), int'(exp_anim));
                end
                if (res_valid && !rv_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected result: face %0d player %0d, none expected",
                                 res_face, res_player);
                    end else begin
                        e = sb.pop_front();
                        chk("res_face", int'(res_face), int'(e.face));
                        chk("res_player", int'(res_player), e.player);
                        chk("gnt at result", int'(gnt), 1 << e.player);
                        chk("grant-to-result latency", cyc - grant_cyc, LAT);
                    end
                end
                gnt_prev = gnt;
                rv_prev  = res_valid;
            end
        end
    end

    task automatic do_roll(input logic [1:0] r, input logic [2:0] rnd, input int exp_p,
                           input logic [2:0] exp_face, input bit withdraw, input bit early_ack);
        req    = r;
        rnd_in = rnd;
        sb.push_back('{exp_face, exp_p});
        for (int i = 0; i < 8 && gnt == '0; i++) @(negedge clk);
        chk("gnt", int'(gnt), 1 << exp_p);
        chk("busy at grant", int'(busy), 1);
        if (withdraw) req = '0;
        if (early_ack) begin
            res_ack = 1'b1;
            @(negedge clk);
            res_ack = 1'b0;
        end
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        chk("res_valid arrives", int'(res_valid), 1);
        req = '0;
        repeat (2) @(negedge clk);
        chk("res_valid held", int'(res_valid), 1);
        chk("res_face held", int'(res_face), int'(exp_face));
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        chk("res_valid after ack", int'(res_valid), 0);
        chk("gnt after ack", int'(gnt), 0);
        chk("busy after ack", int'(busy), 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset gnt", int'(gnt), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset anim_face", int'(anim_face), 0);
        chk("reset res_valid", int'(res_valid), 0);
        chk("reset res_face", int'(res_face), 0);
        chk("reset res_player", int'(res_player), 0);

        // Start a roll, then abort it asynchronously between edges.
        rst    = 1'b0;
        req    = 2'b01;
        rnd_in = 3'd4;
        for (int i = 0; i < 8 && gnt == '0; i++) @(negedge clk);
        chk("gnt before abort", int'(gnt), 1);
        #1 rst = 1'b1;
        #1;
        chk("async reset gnt", int'(gnt), 0);
        chk("async reset busy", int'(busy), 0);
        chk("async reset res_valid", int'(res_valid), 0);
        chk("async reset anim_face", int'(anim_face), 0);
        req = '0;
        @(negedge clk);
        chk("no result after abort", int'(res_valid), 0);
        rst = 1'b0;
        @(negedge clk);

        do_roll(2'b01, 3'd3, 0, 3'd4, 1'b0, 1'b0);  // pointer back at 0 after reset
        do_roll(2'b11, 3'd7, 1, 3'd1, 1'b0, 1'b0);  // out-of-range value folds to 1
        do_roll(2'b11, 3'd5, 0, 3'd6, 1'b0, 1'b1);  // ack during ROLL is ignored
        do_roll(2'b01, 3'd0, 0, 3'd1, 1'b1, 1'b0);  // withdrawal, pointer wraps 1 -> 0
        do_roll(2'b10, 3'd6, 1, 3'd1, 1'b0, 1'b0);

        // Both players held with ack tied high: grants must alternate 0, 1, 0.
        sb.push_back('{3'd3, 0});
        sb.push_back('{3'd3, 1});
        sb.push_back('{3'd3, 0});
        req     = 2'b11;
        rnd_in  = 3'd2;
        res_ack = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("round-robin results drained", sb.size(), 0);
        req = '0;
        @(negedge clk);
        res_ack = 1'b0;
        @(negedge clk);
        chk("idle after round-robin gnt", int'(gnt), 0);
        chk("idle after round-robin busy", int'(busy), 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
